// File: rtl/main_mem_arbiter_pkg.sv
// Shared types and helpers for the main memory arbiter.
package main_mem_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    // Arbiter transaction state.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ERR  = 2'd2
    } arb_state_t;

    // Which requester owns the outstanding transaction.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } arb_owner_t;

    // Request selected by the issue mux.
    typedef struct packed {
        logic              wen;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdat;
    } mem_req_t;

    // Word-aligned and inside the byte address space of main memory.
    function automatic logic addr_legal(input logic [WORD_W-1:0] addr,
                                        input int unsigned       byte_add_w);
        return (addr[1:0] == 2'b00) && ((addr >> byte_add_w) == '0);
    endfunction

endpackage

// File: rtl/main_mem_arb_starve_cnt.sv
// Saturating wait counter: counts consecutive denied IF cycles.
module main_mem_arb_starve_cnt
    import main_mem_arbiter_pkg::*;
#(
    parameter int unsigned IF_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = $clog2(IF_MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt;

    // Clear has precedence; increment holds at the saturation value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(IF_MAX_WAIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Saturation flag gives IF priority in the arbiter.
    always_comb begin
        at_max = (cnt == CNT_W'(IF_MAX_WAIT));
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch (IF)
// and memory access (MA). MA has fixed priority; a starvation counter
// forces an IF grant after a bounded wait. Illegal addresses get an error
// response one cycle after grant without touching memory.
module main_mem_arbiter
    import main_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAIN_MEM_BYTE_ADD_W = 8,
    parameter int unsigned MEM_RD_LAT          = 1,
    parameter int unsigned IF_MAX_WAIT         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdat,
    input  logic        ma_req,
    input  logic        ma_wen,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdat,
    output logic        ma_gnt,
    output logic        ma_done,
    output logic        ma_err,
    output logic [31:0] ma_rdat,
    output logic        mem_cs,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dat_in,
    input  logic [31:0] mem_dat_out
);

    localparam int unsigned LAT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    arb_state_t       state;
    arb_owner_t       owner;
    logic             owner_wen;
    logic [LAT_W-1:0] lat_cnt;

    logic     done_now;
    logic     issue_ok;
    logic     starve_at_max;
    logic     pick_if;
    logic     pick_ma;
    logic     any_gnt;
    logic     req_legal;
    mem_req_t req;

    // Transaction completes this cycle; issue is allowed in IDLE or back-to-back with done.
    always_comb begin
        done_now = !rst && (((state == ARB_BUSY) && (lat_cnt == '0)) || (state == ARB_ERR));
        issue_ok = !rst && ((state == ARB_IDLE) || done_now);
    end

    // Fixed MA priority, overridden by IF once it has waited IF_MAX_WAIT cycles.
    always_comb begin
        pick_if = 1'b0;
        pick_ma = 1'b0;
        if (issue_ok) begin
            if (starve_at_max && if_req) begin
                pick_if = 1'b1;
            end else if (ma_req) begin
                pick_ma = 1'b1;
            end else if (if_req) begin
                pick_if = 1'b1;
            end
        end
        any_gnt = pick_if || pick_ma;
        if_gnt  = pick_if;
        ma_gnt  = pick_ma;
    end

    // Issue mux: IF is always a read with zero write data.
    always_comb begin
        req = '0;
        if (pick_ma) begin
            req.wen  = ma_wen;
            req.addr = ma_addr;
            req.wdat = ma_wdat;
        end else if (pick_if) begin
            req.addr = if_addr;
        end
        req_legal = addr_legal(req.addr, MAIN_MEM_BYTE_ADD_W);
    end

    // Memory port is driven only in the grant cycle of a legal request.
    always_comb begin
        mem_cs     = any_gnt && req_legal;
        mem_wen    = mem_cs && req.wen;
        mem_addr   = mem_cs ? req.addr : '0;
        mem_dat_in = mem_cs ? req.wdat : '0;
    end

    // Route the response to the owner; read data passes straight from memory.
    always_comb begin
        if_done = done_now && (owner == OWN_IF);
        ma_done = done_now && (owner == OWN_MA);
        if_err  = if_done && (state == ARB_ERR);
        ma_err  = ma_done && (state == ARB_ERR);
        if_rdat = (if_done && (state == ARB_BUSY)) ? mem_dat_out : '0;
        ma_rdat = (ma_done && (state == ARB_BUSY) && !owner_wen) ? mem_dat_out : '0;
    end

    // Transaction FSM with owner capture and read latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            owner_wen <= 1'b0;
            lat_cnt   <= '0;
        end else if (any_gnt) begin
            owner     <= pick_ma ? OWN_MA : OWN_IF;
            owner_wen <= req.wen;
            state     <= req_legal ? ARB_BUSY : ARB_ERR;
            lat_cnt   <= req_legal ? LAT_W'(MEM_RD_LAT - 1) : '0;
        end else if (done_now) begin
            state     <= ARB_IDLE;
            owner_wen <= 1'b0;
        end else if (state == ARB_BUSY) begin
            lat_cnt   <= lat_cnt - 1'b1;
        end
    end

    main_mem_arb_starve_cnt #(
        .IF_MAX_WAIT (IF_MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (if_req && !pick_if),
        .clr    (!if_req || pick_if),
        .at_max (starve_at_max)
    );

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Randomized bench for main_mem_arbiter: two instances (read latency 1 and 3)
// checked every cycle against a transaction-level reference model.
module tb_main_mem_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned NCYC = 4000;

    logic clk;
    logic rst;

    logic        if_req     [2];
    logic [31:0] if_addr    [2];
    logic        if_gnt     [2];
    logic        if_done    [2];
    logic        if_err     [2];
    logic [31:0] if_rdat    [2];
    logic        ma_req     [2];
    logic        ma_wen     [2];
    logic [31:0] ma_addr    [2];
    logic [31:0] ma_wdat    [2];
    logic        ma_gnt     [2];
    logic        ma_done    [2];
    logic        ma_err     [2];
    logic [31:0] ma_rdat    [2];
    logic        mem_cs     [2];
    logic        mem_wen    [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_dat_in [2];
    logic [31:0] mem_dat_out[2];

    int unsigned lat  [2] = '{1, 3};
    int unsigned maxw [2] = '{4, 2};

    // Reference model state: one outstanding transaction with an absolute completion cycle.
    bit          m_busy    [2];
    int unsigned m_done_at [2];
    bit          m_own_ma  [2];
    bit          m_err     [2];
    bit          m_wen     [2];
    int unsigned m_starve  [2];
    bit          e_if_gnt  [2];
    bit          e_ma_gnt  [2];

    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned p_if;
    int unsigned p_ma;

    main_mem_arbiter #(
        .MAIN_MEM_BYTE_ADD_W (AW),
        .MEM_RD_LAT          (1),
        .IF_MAX_WAIT         (4)
    ) u_dut0 (
        .clk (clk), .rst (rst),
        .if_req (if_req[0]), .if_addr (if_addr[0]), .if_gnt (if_gnt[0]),
        .if_done (if_done[0]), .if_err (if_err[0]), .if_rdat (if_rdat[0]),
        .ma_req (ma_req[0]), .ma_wen (ma_wen[0]), .ma_addr (ma_addr[0]), .ma_wdat (ma_wdat[0]),
        .ma_gnt (ma_gnt[0]), .ma_done (ma_done[0]), .ma_err (ma_err[0]), .ma_rdat (ma_rdat[0]),
        .mem_cs (mem_cs[0]), .mem_wen (mem_wen[0]), .mem_addr (mem_addr[0]),
        .mem_dat_in (mem_dat_in[0]), .mem_dat_out (mem_dat_out[0])
    );

    main_mem_arbiter #(
        .MAIN_MEM_BYTE_ADD_W (AW),
        .MEM_RD_LAT          (3),
        .IF_MAX_WAIT         (2)
    ) u_dut1 (
        .clk (clk), .rst (rst),
        .if_req (if_req[1]), .if_addr (if_addr[1]), .if_gnt (if_gnt[1]),
        .if_done (if_done[1]), .if_err (if_err[1]), .if_rdat (if_rdat[1]),
        .ma_req (ma_req[1]), .ma_wen (ma_wen[1]), .ma_addr (ma_addr[1]), .ma_wdat (ma_wdat[1]),
        .ma_gnt (ma_gnt[1]), .ma_done (ma_done[1]), .ma_err (ma_err[1]), .ma_rdat (ma_rdat[1]),
        .mem_cs (mem_cs[1]), .mem_wen (mem_wen[1]), .mem_addr (mem_addr[1]),
        .mem_dat_in (mem_dat_in[1]), .mem_dat_out (mem_dat_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(9))
            0: a = 32'h10;
            1: a = 32'h04;
            2: a = 32'h08;
            3: a = 32'h20;
            4: a = 32'h102;
            5: a = 32'h100;
            6: a = $urandom_range(63) * 4;
            7: a = $urandom;
            8: a = 32'hFC;
            default: a = 32'h01 + $urandom_range(2);
        endcase
        return a;
    endfunction

    // New stimulus for instance k, just after the clock edge.
    task automatic drive(input int k);
        if (!if_req[k] || e_if_gnt[k]) begin
            if_req[k]  = ($urandom_range(99) < p_if);
            if_addr[k] = pick_addr();
        end
        if (!ma_req[k] || e_ma_gnt[k]) begin
            ma_req[k]  = ($urandom_range(99) < p_ma);
            ma_wen[k]  = $urandom_range(1);
            ma_addr[k] = pick_addr();
            ma_wdat[k] = $urandom;
        end
        mem_dat_out[k] = ($urandom_range(3) == 0) ? 32'hDEADBEEF : $urandom;
    endtask

    // Predict all outputs of instance k for this cycle, compare, then advance the model.
    task automatic model_cycle(input int k);
        bit          done, issue, g_if, g_ma, legal, cs;
        logic [31:0] a;
        bit          x_if_done, x_ma_done;
        string       p;
        p = $sformatf("d%0d c%0d", k, cyc);
        done = 0; issue = 0; g_if = 0; g_ma = 0; legal = 0; a = '0;
        if (!rst) begin
            done  = m_busy[k] && (cyc == m_done_at[k]);
            issue = !m_busy[k] || done;
            if (issue) begin
                if (if_req[k] && m_starve[k] == maxw[k]) g_if = 1;
                else if (ma_req[k])                       g_ma = 1;
                else if (if_req[k])                       g_if = 1;
            end
            a     = g_if ? if_addr[k] : ma_addr[k];
            legal = (a % 4 == 0) && (a < (32'd1 << AW));
        end
        cs        = (g_if || g_ma) && legal;
        x_if_done = done && !m_own_ma[k];
        x_ma_done = done && m_own_ma[k];

        check({p, " if_gnt"},  if_gnt[k],  g_if);
        check({p, " ma_gnt"},  ma_gnt[k],  g_ma);
        check({p, " if_done"}, if_done[k], x_if_done);
        check({p, " ma_done"}, ma_done[k], x_ma_done);
        check({p, " if_err"},  if_err[k],  x_if_done && m_err[k]);
        check({p, " ma_err"},  ma_err[k],  x_ma_done && m_err[k]);
        check({p, " if_rdat"}, if_rdat[k], (x_if_done && !m_err[k]) ? mem_dat_out[k] : 32'h0);
        check({p, " ma_rdat"}, ma_rdat[k],
              (x_ma_done && !m_err[k] && !m_wen[k]) ? mem_dat_out[k] : 32'h0);
        check({p, " mem_cs"},  mem_cs[k],  cs);
        check({p, " mem_wen"}, mem_wen[k], cs && g_ma && ma_wen[k]);
        check({p, " mem_addr"}, mem_addr[k], cs ? a : 32'h0);
        check({p, " mem_dat_in"}, mem_dat_in[k], (cs && g_ma) ? ma_wdat[k] : 32'h0);

        if (rst) begin
            m_busy[k]   = 0;
            m_starve[k] = 0;
        end else begin
            if (g_if || g_ma) begin
                m_busy[k]    = 1;
                m_done_at[k] = cyc + (legal ? lat[k] : 1);
                m_own_ma[k]  = g_ma;
                m_err[k]     = !legal;
                m_wen[k]     = g_ma && ma_wen[k];
            end else if (done) begin
                m_busy[k] = 0;
            end
            if (if_req[k] && !g_if)
                m_starve[k] = (m_starve[k] < maxw[k]) ? m_starve[k] + 1 : maxw[k];
            else
                m_starve[k] = 0;
        end
        e_if_gnt[k] = g_if;
        e_ma_gnt[k] = g_ma;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            // Both requesters already waiting when reset releases: MA first, then IF.
            if_req[k]      = 1'b1;
            if_addr[k]     = 32'h04;
            ma_req[k]      = 1'b1;
            ma_wen[k]      = 1'b0;
            ma_addr[k]     = 32'h08;
            ma_wdat[k]     = 32'h0;
            mem_dat_out[k] = 32'hDEADBEEF;
            m_busy[k]      = 0;
            m_done_at[k]   = 0;
            m_own_ma[k]    = 0;
            m_err[k]       = 0;
            m_wen[k]       = 0;
            m_starve[k]    = 0;
            e_if_gnt[k]    = 0;
            e_ma_gnt[k]    = 0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c < 1500)      begin p_ma = 50;  p_if = 50; end
            else if (c < 2500) begin p_ma = 100; p_if = 60; end
            else               begin p_ma = 30;  p_if = 80; end
            rst = (c < 3) || (c == 700) || (c == 1801) || (c == 3100) || (c == 3101)
                  || ($urandom_range(299) == 0);
            if (c >= 3) begin
                for (int k = 0; k < 2; k++) drive(k);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) model_cycle(k);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
